// File: rtl/ysyx_23060251_ifu_pkg.sv
// Shared state encoding and sizing helpers for the ifu_fetch_buf fetch front end.
package ysyx_23060251_ifu_pkg;

    typedef enum logic {S_RUN, S_DRAIN} ifu_state_e;

    localparam int unsigned IFU_PC_W    = 32;
    localparam int unsigned IFU_INST_W  = 32;
    localparam int unsigned IFU_DEPTH   = 2;
    localparam int unsigned IFU_ENTRY_W = IFU_PC_W + IFU_INST_W + 1;
    localparam int unsigned IFU_CNT_W   = $clog2(IFU_DEPTH + 1);

    // Counter width able to hold 0..depth inclusive.
    function automatic int unsigned ifu_cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ifu_fetch_buf_if.sv
// Request/response and decoder-side handshake bundle for ifu_fetch_buf.
interface ifu_fetch_buf_if #(
    parameter int unsigned PC_W   = 32,
    parameter int unsigned INST_W = 32
);
    logic              redirect_valid;
    logic [PC_W-1:0]   redirect_pc;
    logic              req_valid;
    logic              req_ready;
    logic [PC_W-1:0]   req_addr;
    logic              resp_valid;
    logic [INST_W-1:0] resp_data;
    logic              resp_err;
    logic              out_valid;
    logic              out_ready;
    logic [PC_W-1:0]   out_pc;
    logic [INST_W-1:0] out_inst;
    logic              out_err;

    modport master (
        input  redirect_valid, redirect_pc, req_ready, resp_valid, resp_data, resp_err, out_ready,
        output req_valid, req_addr, out_valid, out_pc, out_inst, out_err
    );

    modport slave (
        output redirect_valid, redirect_pc, req_ready, resp_valid, resp_data, resp_err, out_ready,
        input  req_valid, req_addr, out_valid, out_pc, out_inst, out_err
    );
endinterface

// File: rtl/ifu_fifo.sv
// Registered instruction FIFO plus the pc tag table written when a fetch request is accepted.
module ifu_fifo
    import ysyx_23060251_ifu_pkg::*;
#(
    parameter int unsigned PC_W   = IFU_PC_W,
    parameter int unsigned INST_W = IFU_INST_W,
    parameter int unsigned DEPTH  = IFU_DEPTH,
    parameter int unsigned CNT_W  = ifu_cnt_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [INST_W-1:0] push_inst,
    input  logic              push_err,
    input  logic              tag_we,
    input  logic [CNT_W-1:0]  tag_off,
    input  logic [PC_W-1:0]   tag_pc,
    output logic [CNT_W-1:0]  count,
    output logic [PC_W-1:0]   head_pc,
    output logic [INST_W-1:0] head_inst,
    output logic              head_err
);
    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned ENTRY_W = PC_W + INST_W + 1;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PC_W-1:0]    tag [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   tag_slot;

    // A request accepted with N responses outstanding lands N slots past the tail.
    assign tag_slot = wr_ptr + tag_off[PTR_W-1:0];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= {tag[wr_ptr], push_inst, push_err};
        if (tag_we)         tag[tag_slot] <= tag_pc;
    end

    assign {head_pc, head_inst, head_err} = mem[rd_ptr];
endmodule

// File: rtl/ifu_fetch_buf.sv
// Decoupled fetch front end: credit-limited in-order requests, response FIFO, redirect drain FSM.
// Optional performance counters are enabled by defining YSYX_23060251_IFU_PERF_EN.
module ifu_fetch_buf
    import ysyx_23060251_ifu_pkg::*;
#(
    parameter int unsigned     PC_W     = IFU_PC_W,
    parameter int unsigned     INST_W   = IFU_INST_W,
    parameter int unsigned     DEPTH    = IFU_DEPTH,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(32'h8000_0000)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    ifu_fetch_buf_if.master    bus
`ifdef YSYX_23060251_IFU_PERF_EN
    ,
    output logic [31:0]        perf_fetch_o,
    output logic [31:0]        perf_stall_o
`endif
);
    localparam int unsigned    CNT_W   = ifu_cnt_w(DEPTH);
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

    ifu_state_e        state, state_nx;
    logic [PC_W-1:0]   fetch_pc, fetch_pc_nx, hold_addr, cur_addr;
    logic              hold, hold_nx;
    logic [CNT_W-1:0]  inflight, inflight_nx, drop_cnt, drop_cnt_nx, fifo_count;
    logic              req_valid, req_acc, resp_ok, push, pop, out_valid, tag_we;
    logic [PC_W-1:0]   head_pc;
    logic [INST_W-1:0] head_inst;
    logic              head_err;

    // A held request keeps its original address even after fetch_pc is redirected.
    assign cur_addr  = hold ? hold_addr : fetch_pc;
    assign req_valid = !rst_i && (hold ||
                       (state == S_RUN && ({1'b0, inflight} + {1'b0, fifo_count}) < DEPTH_C));
    assign req_acc   = req_valid && bus.req_ready;
    assign resp_ok   = bus.resp_valid && (inflight != '0);
    assign out_valid = (fifo_count != '0);
    assign pop       = out_valid && bus.out_ready;
    assign push      = resp_ok && (state == S_RUN) && !bus.redirect_valid;

    always_comb begin
        state_nx    = state;
        fetch_pc_nx = fetch_pc;
        drop_cnt_nx = drop_cnt;
        tag_we      = 1'b0;
        inflight_nx = inflight + CNT_W'(req_acc) - CNT_W'(resp_ok);
        hold_nx     = req_valid && !bus.req_ready;
        if (bus.redirect_valid) begin
            fetch_pc_nx = bus.redirect_pc;
            drop_cnt_nx = inflight_nx;
            state_nx    = (inflight_nx != '0 || hold_nx) ? S_DRAIN : S_RUN;
        end else begin
            case (state)
                S_RUN: begin
                    if (req_acc) begin
                        fetch_pc_nx = fetch_pc + PC_W'(4);
                        tag_we      = 1'b1;
                    end
                end
                S_DRAIN: begin
                    // A stale held request joins the drop count once accepted.
                    drop_cnt_nx = drop_cnt + CNT_W'(req_acc) - CNT_W'(resp_ok);
                    if (drop_cnt == '0 && !hold) state_nx = S_RUN;
                end
                default: state_nx = S_RUN;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= S_RUN;
            fetch_pc <= RESET_PC;
            hold     <= 1'b0;
            inflight <= '0;
            drop_cnt <= '0;
        end else begin
            state    <= state_nx;
            fetch_pc <= fetch_pc_nx;
            hold     <= hold_nx;
            inflight <= inflight_nx;
            drop_cnt <= drop_cnt_nx;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!hold) hold_addr <= fetch_pc;
    end

    ifu_fifo #(
        .PC_W   (PC_W),
        .INST_W (INST_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) u_fifo (
        .clk       (clk_i),
        .rst       (rst_i),
        .push      (push),
        .pop       (pop),
        .flush     (bus.redirect_valid),
        .push_inst (bus.resp_data),
        .push_err  (bus.resp_err),
        .tag_we    (tag_we),
        .tag_off   (inflight),
        .tag_pc    (cur_addr),
        .count     (fifo_count),
        .head_pc   (head_pc),
        .head_inst (head_inst),
        .head_err  (head_err)
    );

    assign bus.req_valid = req_valid;
    assign bus.req_addr  = req_valid ? cur_addr : '0;
    assign bus.out_valid = out_valid;
    assign bus.out_pc    = out_valid ? head_pc : '0;
    assign bus.out_inst  = out_valid ? head_inst : '0;
    assign bus.out_err   = out_valid && head_err;

`ifdef YSYX_23060251_IFU_PERF_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_fetch_o <= '0;
            perf_stall_o <= '0;
        end else begin
            if (pop)                          perf_fetch_o <= perf_fetch_o + 32'd1;
            if (bus.out_ready && !out_valid)  perf_stall_o <= perf_stall_o + 32'd1;
        end
    end
`endif

    resp_without_request: assert property (@(posedge clk_i) disable iff (rst_i)
        !(bus.resp_valid && inflight == '0));
endmodule
